serial_addsub: RTL

//  Parametrised multi-cycle (digit-serial) adder/subtractor, successor to the

---
 rtl/serial_addsub.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with valid/ready handshakes on both sides and registered carry/overflow flags.
module serial_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("serial_addsub: CHUNK (%0d) must divide WIDTH (%0d)", CHUNK, WIDTH);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CHUNK:0]   sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      carry_q <= 1'b0;
      k_q     <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operands shift right one chunk per cycle so the adder always sees bits
  // [CHUNK-1:0]; the result fills from the top, landing aligned after NCHUNK steps.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    carry_d = carry_q;
    k_d     = k_q;
    f_d     = f_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    sum     = '0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
          carry_d = sub;
          k_d     = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sum     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, carry_q};
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = (res_q >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        carry_d = sum[CHUNK];
        k_d     = k_q + KW'(1);
        if (k_q == KLAST) begin
          state_d = DONE;
          f_d     = res_d;
          cout_d  = sum[CHUNK];
          ovf_d   = (a_msb_q == b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign f         = f_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
